// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage core: merges load-use, branch, data-memory
// wait and multi-cycle EXE hazards into per-stage enables/flushes plus perf counters.
module pipeline_sequencer #(
    parameter int MULDIV_LAT  = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Load_hazard,
    input  logic        Branch_hazard,
    input  logic        muldiv_start_exe,
    input  logic        dmem_req_mem,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        muldiv_done,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    typedef enum logic {RUN, BUSY} state_t;

    localparam logic [3:0]  MD_LOAD = 4'(MULDIV_LAT - 2);
    localparam logic [15:0] TO_LIM  = 16'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic mem_freeze, branch_take;
    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, done_c;

    assign mem_freeze = dmem_req_mem & ~dmem_ack;

    always_comb begin
        pc_en_c        = 1'b1;
        if_id_en_c     = 1'b1;
        id_ex_en_c     = 1'b1;
        ex_mem_en_c    = 1'b1;
        mem_wb_en_c    = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        done_c         = 1'b0;
        branch_take    = 1'b0;
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;

        // The mul/div countdown keeps running through memory freezes.
        if (state_q == BUSY && md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;

        if (mem_freeze) begin
            pc_en_c     = 1'b0;
            if_id_en_c  = 1'b0;
            id_ex_en_c  = 1'b0;
            ex_mem_en_c = 1'b0;
            mem_wb_en_c = 1'b0;
        end else if (state_q == BUSY) begin
            if (md_cnt_q != 4'd0) begin
                pc_en_c        = 1'b0;
                if_id_en_c     = 1'b0;
                id_ex_en_c     = 1'b0;
                ex_mem_flush_c = 1'b1;
            end else begin
                // Release cycle: start is still high for this same op, so it is ignored.
                done_c  = 1'b1;
                state_d = RUN;
                if (Load_hazard) begin
                    pc_en_c       = 1'b0;
                    if_id_en_c    = 1'b0;
                    id_ex_flush_c = 1'b1;
                end
            end
        end else if (Branch_hazard) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            branch_take   = 1'b1;
        end else if (muldiv_start_exe) begin
            pc_en_c        = 1'b0;
            if_id_en_c     = 1'b0;
            id_ex_en_c     = 1'b0;
            ex_mem_flush_c = 1'b1;
            md_cnt_d       = MD_LOAD;
            state_d        = BUSY;
        end else if (Load_hazard) begin
            pc_en_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_flush_c = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d   = stall_cnt_q + {31'd0, ~pc_en_c};
        flush_cnt_d   = flush_cnt_q + {31'd0, branch_take};
        wait_cnt_d    = 16'd0;
        if (mem_freeze)
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
        mem_timeout_d = mem_timeout_q | (wait_cnt_d >= TO_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            md_cnt_q      <= 4'd0;
            wait_cnt_q    <= 16'd0;
            stall_cnt_q   <= 32'd0;
            flush_cnt_q   <= 32'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Everything is held quiet while reset is asserted; a flush never escapes without its enable.
    assign pc_en        = rst_n & pc_en_c;
    assign if_id_en     = rst_n & if_id_en_c;
    assign id_ex_en     = rst_n & id_ex_en_c;
    assign ex_mem_en    = rst_n & ex_mem_en_c;
    assign mem_wb_en    = rst_n & mem_wb_en_c;
    assign if_id_flush  = rst_n & if_id_en_c & if_id_flush_c;
    assign id_ex_flush  = rst_n & id_ex_en_c & id_ex_flush_c;
    assign ex_mem_flush = rst_n & ex_mem_en_c & ex_mem_flush_c;
    assign muldiv_done  = rst_n & done_c;
    assign mem_timeout  = mem_timeout_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with MULDIV_LAT=4, MEM_TIMEOUT=3.
module tb_pipeline_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic Load_hazard, Branch_hazard, muldiv_start_exe, dmem_req_mem, dmem_ack;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, muldiv_done, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    // Output vector: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, done}
    localparam logic [8:0] O_ZERO  = 9'b00000_000_0;
    localparam logic [8:0] O_ALL1  = 9'b11111_000_0;
    localparam logic [8:0] O_LOAD  = 9'b00111_010_0;
    localparam logic [8:0] O_BR    = 9'b11111_110_0;
    localparam logic [8:0] O_MD    = 9'b00011_001_0;
    localparam logic [8:0] O_REL   = 9'b11111_000_1;
    localparam logic [8:0] O_RELLD = 9'b00111_010_1;

    pipeline_sequencer #(.MULDIV_LAT(4), .MEM_TIMEOUT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .Load_hazard(Load_hazard), .Branch_hazard(Branch_hazard),
        .muldiv_start_exe(muldiv_start_exe),
        .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .muldiv_done(muldiv_done), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    wire [8:0] outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush, muldiv_done};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic br, input logic md,
                         input logic req, input logic ack);
        Load_hazard = ld; Branch_hazard = br; muldiv_start_exe = md;
        dmem_req_mem = req; dmem_ack = ack;
    endtask

    // Check the combinational decision mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [8:0] exp);
        #2;
        check_eq(tag, {23'd0, outs}, {23'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 1);
        #2;
        check_eq("rst_outs", {23'd0, outs}, {23'd0, O_ZERO});
        check_eq("rst_stall", stall_cnt, 0);
        check_eq("rst_flush", flush_cnt, 0);
        check_eq("rst_to", {31'd0, mem_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        cyc("idle0", O_ALL1);

        // Load-use: one stall cycle
        drive(1, 0, 0, 0, 0); cyc("load", O_LOAD);
        check_eq("load_stall", stall_cnt, 1);
        drive(0, 0, 0, 0, 0); cyc("load_after", O_ALL1);
        check_eq("load_stall2", stall_cnt, 1);

        // Branch beats load and mul/div start
        drive(1, 1, 0, 0, 0); cyc("br_ld", O_BR);
        check_eq("br_flush", flush_cnt, 1);
        check_eq("br_stall", stall_cnt, 1);
        drive(0, 1, 1, 0, 0); cyc("br_md", O_BR);
        check_eq("br_flush2", flush_cnt, 2);
        drive(0, 0, 0, 0, 0); cyc("br_md_after", O_ALL1);

        // Two back-to-back mul/div ops, start held throughout
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 0, 0);
            for (int i = 0; i < 3; i++) cyc("md_stall", O_MD);
            cyc("md_rel", O_REL);
        end
        check_eq("md_stall_cnt", stall_cnt, 7);
        drive(0, 0, 0, 0, 0); cyc("md_idle", O_ALL1);

        // Release cycle coinciding with a load-use hazard
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("mdl_stall", O_MD);
        drive(1, 0, 1, 0, 0); cyc("mdl_rel", O_RELLD);
        drive(0, 0, 0, 0, 0); cyc("mdl_idle", O_ALL1);
        check_eq("mdl_stall_cnt", stall_cnt, 11);

        // Memory freeze inside BUSY; also crosses the timeout of 3
        drive(0, 0, 1, 0, 0); cyc("fz_start", O_MD);
        drive(0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc("fz_busy", O_ZERO);
            check_eq("fz_to", {31'd0, mem_timeout}, (i >= 2) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 1, 1, 1); cyc("fz_rel", O_REL);
        drive(0, 0, 0, 0, 0); cyc("fz_idle", O_ALL1);
        check_eq("fz_stall_cnt", stall_cnt, 17);
        check_eq("fz_to_sticky", {31'd0, mem_timeout}, 1);

        // Reset mid-BUSY aborts with no carry-over
        drive(0, 0, 1, 0, 0); cyc("ab_start", O_MD);
        #2;
        check_eq("ab_busy", {23'd0, outs}, {23'd0, O_MD});
        rst_n = 1'b0;
        #1;
        check_eq("ab_outs", {23'd0, outs}, {23'd0, O_ZERO});
        check_eq("ab_stall", stall_cnt, 0);
        check_eq("ab_flush", flush_cnt, 0);
        check_eq("ab_to", {31'd0, mem_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        cyc("ab_idle0", O_ALL1);
        cyc("ab_idle1", O_ALL1);

        // Two short freezes separated by an ack do not reach the timeout
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1, 0);
            cyc("sf_frz", O_ZERO);
            cyc("sf_frz", O_ZERO);
            drive(0, 0, 0, 1, 1); cyc("sf_ack", O_ALL1);
        end
        check_eq("sf_to", {31'd0, mem_timeout}, 0);
        check_eq("sf_stall", stall_cnt, 4);

        // Three-cycle freeze sets the sticky timeout
        drive(0, 0, 0, 1, 0);
        cyc("to_f1", O_ZERO);
        check_eq("to_1", {31'd0, mem_timeout}, 0);
        cyc("to_f2", O_ZERO);
        check_eq("to_2", {31'd0, mem_timeout}, 0);
        cyc("to_f3", O_ZERO);
        check_eq("to_3", {31'd0, mem_timeout}, 1);
        drive(0, 0, 0, 1, 1); cyc("to_ack", O_ALL1);
        drive(0, 0, 0, 0, 0); cyc("to_idle", O_ALL1);
        check_eq("to_sticky", {31'd0, mem_timeout}, 1);
        check_eq("to_stall", stall_cnt, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
